jk_bank_driver: RTL and testbench

- Initiator side of the JK flip-flop interface: drives J/K excitation onto a bank of WIDTH negedge-clocked JK flip-flops so the bank reaches a requested target word.
- Reads the bank's q outputs back, verifies the result, retries on mismatch, and reports done or error.
- Sits between a register-write source (valid/ready) and a JK storage bank.
- Controller runs on posedge clk, so J/K are stable across the bank's negedge sample point.

---
 rtl/jk_bank_driver.sv | 83 ++++++++
 tb/tb_jk_bank_driver.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives J/K onto a negedge JK flip-flop bank until it matches a target word.
// Verifies the bank after each drive, retries up to MAX_RETRY times, then pulses done or err.
module jk_bank_driver #(
  parameter int WIDTH = 8,
  parameter int MAX_RETRY = 3,
  parameter int USE_TOGGLE = 0,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [RW-1:0]    retry_cnt
);
  typedef enum logic [2:0] {IDLE, DRIVE, CHECK, DONE, ERR} state_e;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
  state_e state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d, j_q, j_d, k_q, k_d, em_q, em_d, drv_tgt, diff;
  logic [RW-1:0] retry_q, retry_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, accept;
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      em_q    <= '0;
      retry_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      em_q    <= em_d;
      retry_q <= retry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = tgt_valid ? DRIVE : IDLE;
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = (q_in == tgt_q) ? DONE : (retry_q == MAX_R) ? ERR : DRIVE;
      default: state_d = IDLE;
    endcase
  end
  // J/K are registered on the edge entering DRIVE, so the difference uses the target about to be driven
  always_comb begin
    accept  = (state_q == IDLE) && tgt_valid;
    drv_tgt = (state_q == IDLE) ? tgt_data : tgt_q;
    diff    = drv_tgt ^ q_in;
    tgt_d   = accept ? tgt_data : tgt_q;
    j_d     = (state_d == DRIVE) ? ((USE_TOGGLE != 0) ? diff : diff & drv_tgt) : '0;
    k_d     = (state_d == DRIVE) ? ((USE_TOGGLE != 0) ? diff : diff & ~drv_tgt) : '0;
    busy_d  = (state_d == DRIVE) || (state_d == CHECK);
    done_d  = state_d == DONE;
    err_d   = state_d == ERR;
    retry_d = accept ? '0 : ((state_q == CHECK) && (state_d == DRIVE)) ? retry_q + RW'(1) : retry_q;
    em_d    = accept ? '0 : (state_d == ERR) ? tgt_q ^ q_in : em_q;
  end
  assign tgt_ready = state_q == IDLE;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = em_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: two driver instances (set/reset and toggle) share stimulus, each with its own JK bank model.
// Expected behaviour comes from a transaction-level model of drive attempts and retries.
module tb_jk_bank_driver;
  localparam int W = 4, MR = 3, RW = 2;
  logic clk = 1'b0, clear = 1'b0, tgt_valid = 1'b0, load = 1'b0;
  logic [W-1:0] tgt_data = '0, load_val = '0, stuck = '0;
  logic [W-1:0] bank0 = '0, bank1 = '0;
  int stuck_left = 0, load_n = 0, n_chk = 0, n_err = 0;
  logic [W-1:0] j0, k0, j1, k1, em0, em1;
  logic rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
  logic [RW-1:0] rc0, rc1;
  always #5 clk = ~clk;
  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(0)) dut0 (
    .clk(clk), .clear(clear), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy0),
    .q_in(bank0), .j(j0), .k(k0), .busy(busy0), .done(done0), .err(err0), .err_mask(em0), .retry_cnt(rc0));
  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(1)) dut1 (
    .clk(clk), .clear(clear), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy1),
    .q_in(bank1), .j(j1), .k(k1), .busy(busy1), .done(done1), .err(err1), .err_mask(em1), .retry_cnt(rc1));
  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, jj, kk);
    return (jj & ~kk) | (jj & kk & ~q) | (~jj & ~kk & q);
  endfunction
  // Stuck-at-0 bits stay stuck for the first stuck_left drives that actually excite the bank
  always @(negedge clk) begin
    if (load) begin
      bank0 <= load_val;
      bank1 <= load_val;
      stuck_left <= load_n;
    end else begin
      bank0 <= jk_next(bank0, j0, k0) & ~((stuck_left > 0) ? stuck : '0);
      bank1 <= jk_next(bank1, j1, k1) & ~((stuck_left > 0) ? stuck : '0);
      if ((j0 | k0) != '0 && stuck_left > 0) stuck_left <= stuck_left - 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load_bank(input logic [W-1:0] b, input logic [W-1:0] s, input int n);
    stuck = s;
    load_val = (n > 0) ? b & ~s : b;
    load_n = n;
    load = 1'b1;
    @(negedge clk);
    #1 load = 1'b0;
  endtask
  task automatic run_txn(input logic [W-1:0] b, input logic [W-1:0] t, input logic [W-1:0] s, input int n);
    logic [W-1:0] ej0[MR+1], ek0[MR+1], ej1[MR+1];
    logic [W-1:0] cur, d, mask;
    int att, lat, a;
    bit ok;
    load_bank(b, s, n);
    cur = (n > 0) ? b & ~s : b;
    ok = 0;
    att = MR;
    for (int i = 0; i <= MR; i++) begin
      d = t ^ cur;
      ej0[i] = d & t;
      ek0[i] = d & ~t;
      ej1[i] = d;
      cur = ((cur & ~d) | (t & d)) & ~((i < n) ? s : '0);
      if (cur == t) begin
        ok = 1;
        att = i;
        break;
      end
    end
    lat = 3 + 2 * att;
    mask = ok ? '0 : t ^ cur;
    check("ready_before", rdy0, 1);
    tgt_valid = 1'b1;
    tgt_data = t;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      a = (c - 1) / 2;
      check("no_jk_conflict", j0 & k0, 0);
      if (c < lat) begin
        check("busy", busy0, 1);
        check("ready_low", rdy0, 0);
        check("no_pulse", {done0, err0, done1, err1}, 0);
        check("retry_cnt", rc0, a);
        check("err_mask_clr", em0, 0);
        if (c % 2 == 1) begin
          check("j_drive", j0, ej0[a]);
          check("k_drive", k0, ek0[a]);
          check("jk_toggle", {j1, k1}, {ej1[a], ej1[a]});
        end else
          check("jk_check", {j0, k0, j1, k1}, 0);
      end else if (c == lat) begin
        check("done", {done0, done1}, ok ? 2'b11 : 2'b00);
        check("err", {err0, err1}, ok ? 2'b00 : 2'b11);
        check("busy_end", {busy0, rdy0}, 0);
        check("retry_final", {rc0, rc1}, {att[RW-1:0], att[RW-1:0]});
        check("err_mask", {em0, em1}, {mask, mask});
        tgt_valid = 1'b0;
      end else begin
        check("idle_after", {rdy0, busy0, done0, err0}, 4'b1000);
        check("err_mask_hold", em0, mask);
        check("bank_final", bank0, cur);
      end
    end
  endtask
  initial begin
    logic [W-1:0] b0;
    #1;
    check("rst_ready", {rdy0, rdy1}, 2'b11);
    check("rst_jk", {j0, k0, j1, k1}, 0);
    check("rst_flags", {busy0, done0, err0, rc0, em0}, 0);
    @(negedge clk);
    clear = 1'b1;
    run_txn(4'b0000, 4'b1010, 4'b0000, 0);
    run_txn(4'b0110, 4'b0110, 4'b0000, 0);
    run_txn(4'b0011, 4'b0101, 4'b0000, 0);
    run_txn(4'b0000, 4'b0100, 4'b0100, 1000);
    run_txn(4'b0000, 4'b0100, 4'b0100, 1);
    b0 = 4'b1001;
    load_bank(b0, 4'b0000, 0);
    tgt_valid = 1'b1;
    tgt_data = 4'b0110;
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    check("clr_jk", {j0, k0, j1, k1}, 0);
    check("clr_flags", {busy0, done0, err0, busy1, done1, err1}, 0);
    check("clr_ready", {rdy0, rdy1}, 2'b11);
    check("clr_regs", {rc0, em0}, 0);
    tgt_valid = 1'b0;
    @(negedge clk);
    check("clr_bank_hold", bank0, b0);
    clear = 1'b1;
    run_txn(4'b1001, 4'b0110, 4'b0000, 0);
    for (int i = 0; i < 40; i++)
      run_txn(W'($urandom), W'($urandom), ($urandom_range(0, 2) == 0) ? W'($urandom) : '0, $urandom_range(0, 4));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
